// File: rtl/bpu_pkg.sv
// Shared types and default sizing for the gshare branch predictor slice.
package bpu_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_state_e;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned IDX_W_DEF  = 5;
  localparam int unsigned HIST_W_DEF = 5;
  localparam int unsigned CTR_W_DEF  = 2;
  localparam int unsigned CNT_W_DEF  = 16;

endpackage : bpu_pkg

// File: rtl/gshare_bpu_if.sv
// Fetch/resolve/statistics bundle between the pipeline (master) and the predictor (slave).
interface gshare_bpu_if
  import bpu_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic            mode_gshare;
  logic [PC_W-1:0] fetch_pc;
  logic            fetch_valid;
  logic            stall;
  logic            flush;
  logic            upd_valid;
  logic            upd_taken;
  logic            pred_taken;
  logic            mispredict;
  logic            init_busy;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output mode_gshare, fetch_pc, fetch_valid, stall, flush, upd_valid, upd_taken,
    input  pred_taken, mispredict, init_busy, branch_cnt, miss_cnt
  );

  modport slave (
    input  mode_gshare, fetch_pc, fetch_valid, stall, flush, upd_valid, upd_taken,
    output pred_taken, mispredict, init_busy, branch_cnt, miss_cnt
  );

endinterface : gshare_bpu_if

// File: rtl/bpu_sat_ctr.sv
// Saturating up/down counter next-state function for one PHT entry.
module bpu_sat_ctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] ctr_nxt
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_MIN = '0;

  always_comb begin
    ctr_nxt = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) ctr_nxt = ctr + CTR_W'(1);
    end else begin
      if (ctr != CTR_MIN) ctr_nxt = ctr - CTR_W'(1);
    end
  end

endmodule : bpu_sat_ctr

// File: rtl/gshare_bpu.sv
// Gshare/bimodal direction predictor with PHT self-initialisation, ID/EX index tracking
// and resolved-branch statistics.
module gshare_bpu
  import bpu_pkg::*;
#(
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned HIST_W   = HIST_W_DEF,
  parameter int unsigned CTR_W    = CTR_W_DEF,
  parameter int unsigned CTR_INIT = (1 << CTR_W) - 1,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  gshare_bpu_if.slave  bus
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  bpu_state_e       state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [HIST_W-1:0] hist_q, hist_d, hist_shift;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             id_valid_q, id_valid_d;
  logic [IDX_W-1:0] id_idx_q, id_idx_d;
  logic             id_pred_q, id_pred_d;
  logic             ex_valid_q, ex_valid_d;
  logic [IDX_W-1:0] ex_idx_q, ex_idx_d;
  logic             ex_pred_q, ex_pred_d;

  logic [CTR_W-1:0] pht_q [ENTRIES];

  logic [IDX_W-1:0] pc_idx, hist_ext, fetch_idx;
  logic [CTR_W-1:0] rd_ctr, upd_ctr, ctr_nxt;
  logic             init_busy, pred_taken, mispredict, upd_en;
  logic             pht_we;
  logic [IDX_W-1:0] pht_waddr;
  logic [CTR_W-1:0] pht_wdata;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{bus.fetch_pc[PC_W-1:IDX_W+2], bus.fetch_pc[1:0]};

  // Fetch-side index and prediction read (no bypass from a same-cycle write).
  always_comb begin
    pc_idx     = bus.fetch_pc[IDX_W+1:2];
    hist_ext   = IDX_W'(hist_q);
    fetch_idx  = bus.mode_gshare ? (pc_idx ^ hist_ext) : pc_idx;
    rd_ctr     = pht_q[fetch_idx];
    pred_taken = ~init_busy & rd_ctr[CTR_W-1];
  end

  assign upd_en     = bus.upd_valid & ex_valid_q & (state_q == RUN);
  assign mispredict = bus.upd_valid & ex_valid_q & (ex_pred_q != bus.upd_taken);
  assign upd_ctr    = pht_q[ex_idx_q];

  bpu_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr     (upd_ctr),
    .inc     (bus.upd_taken),
    .ctr_nxt (ctr_nxt)
  );

  // Init/run sequencing; INIT owns the single PHT write port while active.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    init_busy  = (state_q == INIT);
    pht_we     = 1'b0;
    pht_waddr  = ex_idx_q;
    pht_wdata  = ctr_nxt;
    case (state_q)
      INIT: begin
        pht_we     = 1'b1;
        pht_waddr  = init_ptr_q;
        pht_wdata  = CTR_W'(CTR_INIT);
        init_ptr_d = init_ptr_q + IDX_W'(1);
        if (init_ptr_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
      end
      RUN: begin
        pht_we = upd_en;
      end
      default: state_d = INIT;
    endcase
  end

  // ID/EX tracking of the fetched index and its prediction.
  always_comb begin
    id_valid_d = id_valid_q;
    id_idx_d   = id_idx_q;
    id_pred_d  = id_pred_q;
    ex_valid_d = ex_valid_q;
    ex_idx_d   = ex_idx_q;
    ex_pred_d  = ex_pred_q;
    if (!bus.stall) begin
      id_valid_d = bus.fetch_valid & ~bus.flush & ~init_busy;
      id_idx_d   = fetch_idx;
      id_pred_d  = pred_taken;
      ex_valid_d = id_valid_q;
      ex_idx_d   = id_idx_q;
      ex_pred_d  = id_pred_q;
    end else if (bus.flush) begin
      id_valid_d = 1'b0;
    end
  end

  generate
    if (HIST_W == 1) begin : g_hist1
      assign hist_shift = bus.upd_taken;
    end else begin : g_histn
      assign hist_shift = {hist_q[HIST_W-2:0], bus.upd_taken};
    end
  endgenerate

  // History and saturating statistics advance only on a committed update.
  always_comb begin
    hist_d       = hist_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (upd_en) begin
      hist_d = hist_shift;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      init_ptr_q   <= '0;
      hist_q       <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
      id_valid_q   <= 1'b0;
      id_idx_q     <= '0;
      id_pred_q    <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_idx_q     <= '0;
      ex_pred_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      hist_q       <= hist_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      id_valid_q   <= id_valid_d;
      id_idx_q     <= id_idx_d;
      id_pred_q    <= id_pred_d;
      ex_valid_q   <= ex_valid_d;
      ex_idx_q     <= ex_idx_d;
      ex_pred_q    <= ex_pred_d;
    end
  end

  // Table storage has no reset; INIT rewrites every entry after reset.
  always_ff @(posedge clk) begin
    if (pht_we && !reset) pht_q[pht_waddr] <= pht_wdata;
  end

  assign bus.pred_taken = pred_taken;
  assign bus.mispredict = mispredict;
  assign bus.init_busy  = init_busy;
  assign bus.branch_cnt = branch_cnt_q;
  assign bus.miss_cnt   = miss_cnt_q;

endmodule : gshare_bpu
